// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and the load saturation helper used by
// the pulse counter and its per-decade cells.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Clamp a raw nibble into the legal BCD range 0..9.
  function automatic bcd_digit_t bcd_sat(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_pulse_counter_if.sv
// Command/result bundle between a pulse source and the BCD pulse counter.
// The slave side is the counter; the master side issues the commands.
interface bcd_pulse_counter_if #(
  parameter int DIGITS = 4
);

  logic                  en;
  logic                  inc;
  logic                  dec;
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   bcd;
  logic                  carry;
  logic                  borrow;
  logic                  changed;

  modport slave (
    input  en, inc, dec, clr, load, load_val,
    output bcd, carry, borrow, changed
  );

  modport master (
    output en, inc, dec, clr, load, load_val,
    input  bcd, carry, borrow, changed
  );

endinterface

// File: rtl/bcd_pulse_counter_decade.sv
// One BCD decade: a single digit register with clear/load/up/down control and
// combinational carry/borrow outputs that feed the next decade in the chain.
module bcd_decade
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up,
  input  logic       down,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit,
  output logic       cout,
  output logic       bout
);

  bcd_digit_t digit_nxt;

  assign cout = up   & (digit == BCD_MAX);
  assign bout = down & (digit == BCD_ZERO);

  always_comb begin
    digit_nxt = digit;
    if (clr)
      digit_nxt = BCD_ZERO;
    else if (load)
      digit_nxt = bcd_sat(load_digit);
    else if (up)
      digit_nxt = (digit == BCD_MAX) ? BCD_ZERO : digit + 4'd1;
    else if (down)
      digit_nxt = (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit <= BCD_ZERO;
    else        digit <= digit_nxt;
  end

  a_digit_legal: assert property (@(posedge clk) disable iff (!rst_n) digit <= BCD_MAX);

endmodule

// File: rtl/bcd_pulse_counter.sv
// Multi-decade BCD up/down counter driven by single-cycle inc/dec pulses, with
// registered carry/borrow/changed pulses aligned to the updated count.
module bcd_pulse_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  bcd_pulse_counter_if.slave          pc
);

  logic                     step_up;
  logic                     step_dn;
  logic [DIGITS:0]          up_c;
  logic [DIGITS:0]          dn_c;
  bcd_digit_t [DIGITS-1:0]  digits;
  bcd_digit_t [DIGITS-1:0]  load_sat;
  logic                     cur_zero;
  logic                     load_diff;
  logic                     changed_nxt;
  logic                     carry_q;
  logic                     borrow_q;
  logic                     changed_q;

  // clr and load take priority, so they suppress the count step at the chain head.
  assign step_up = pc.en & pc.inc & ~pc.dec & ~pc.clr & ~pc.load;
  assign step_dn = pc.en & pc.dec & ~pc.inc & ~pc.clr & ~pc.load;

  assign up_c[0] = step_up;
  assign dn_c[0] = step_dn;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    assign load_sat[k] = bcd_sat(pc.load_val[4*k +: 4]);

    bcd_decade u_dec (
      .clk        (clk),
      .rst_n      (rst_n),
      .up         (up_c[k]),
      .down       (dn_c[k]),
      .clr        (pc.clr),
      .load       (pc.load),
      .load_digit (load_sat[k]),
      .digit      (digits[k]),
      .cout       (up_c[k+1]),
      .bout       (dn_c[k+1])
    );
  end

  assign cur_zero  = (digits == '0);
  assign load_diff = (load_sat != digits);

  // Any real step always moves the value; clr/load only count as a change if they do.
  always_comb begin
    changed_nxt = 1'b0;
    if (pc.clr)
      changed_nxt = ~cur_zero;
    else if (pc.load)
      changed_nxt = load_diff;
    else
      changed_nxt = step_up | step_dn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q   <= 1'b0;
      borrow_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      carry_q   <= up_c[DIGITS];
      borrow_q  <= dn_c[DIGITS];
      changed_q <= changed_nxt;
    end
  end

  assign pc.bcd     = digits;
  assign pc.carry   = carry_q;
  assign pc.borrow  = borrow_q;
  assign pc.changed = changed_q;

endmodule

// File: tb/tb_bcd_pulse_counter.sv
// Directed bench for bcd_pulse_counter: a 4-decade instance plus a cascaded
// pair of 1-decade instances, checked against hand-computed values.
module tb_bcd_pulse_counter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bcd_pulse_counter_if #(.DIGITS(4)) pc ();
  bcd_pulse_counter_if #(.DIGITS(1)) lo ();
  bcd_pulse_counter_if #(.DIGITS(1)) hi ();

  bcd_pulse_counter #(.DIGITS(4)) dut    (.clk(clk), .rst_n(rst_n), .pc(pc));
  bcd_pulse_counter #(.DIGITS(1)) dut_lo (.clk(clk), .rst_n(rst_n), .pc(lo));
  bcd_pulse_counter #(.DIGITS(1)) dut_hi (.clk(clk), .rst_n(rst_n), .pc(hi));

  assign hi.inc = lo.carry;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one command for a single edge, then sample 1 time unit after it.
  task automatic cmd(input logic en, input logic inc, input logic dec,
                     input logic clr, input logic load, input logic [15:0] val);
    pc.en = en; pc.inc = inc; pc.dec = dec; pc.clr = clr; pc.load = load; pc.load_val = val;
    @(posedge clk); #1;
    pc.en = 1'b0; pc.inc = 1'b0; pc.dec = 1'b0; pc.clr = 1'b0; pc.load = 1'b0; pc.load_val = '0;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] b, input logic c,
                         input logic br, input logic ch);
    chk({tag, ".bcd"},     pc.bcd,     b);
    chk({tag, ".carry"},   pc.carry,   c);
    chk({tag, ".borrow"},  pc.borrow,  br);
    chk({tag, ".changed"}, pc.changed, ch);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    pc.en = 0; pc.inc = 0; pc.dec = 0; pc.clr = 0; pc.load = 0; pc.load_val = '0;
    lo.en = 0; lo.inc = 0; lo.dec = 0; lo.clr = 0; lo.load = 0; lo.load_val = '0;
    hi.en = 1; hi.dec = 0; hi.clr = 0; hi.load = 0; hi.load_val = '0;
    #12;
    chk_all("reset", 16'h0000, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("post_reset", 16'h0000, 0, 0, 0);

    // Ripple across two decades
    cmd(0, 0, 0, 0, 1, 16'h0099);
    chk_all("load_0099", 16'h0099, 0, 0, 1);
    cmd(1, 1, 0, 0, 0, 16'h0000);
    chk_all("inc_0100", 16'h0100, 0, 0, 1);

    // Up-wrap with one-cycle carry
    cmd(0, 0, 0, 0, 1, 16'h9999);
    cmd(1, 1, 0, 0, 0, 16'h0000);
    chk_all("wrap_up", 16'h0000, 1, 0, 1);
    cmd(0, 0, 0, 0, 0, 16'h0000);
    chk_all("wrap_up_idle", 16'h0000, 0, 0, 0);

    // Down-wrap with one-cycle borrow
    cmd(1, 0, 1, 0, 0, 16'h0000);
    chk_all("wrap_dn", 16'h9999, 0, 1, 1);
    cmd(0, 0, 0, 0, 0, 16'h0000);
    chk_all("wrap_dn_idle", 16'h9999, 0, 0, 0);
    cmd(0, 0, 0, 0, 1, 16'h1000);
    cmd(1, 0, 1, 0, 0, 16'h0000);
    chk_all("dec_0999", 16'h0999, 0, 0, 1);

    // Simultaneous inc/dec and disabled count
    cmd(0, 0, 0, 0, 1, 16'h0500);
    cmd(1, 1, 1, 0, 0, 16'h0000);
    chk_all("inc_dec", 16'h0500, 0, 0, 0);
    cmd(0, 1, 0, 0, 0, 16'h0000);
    chk_all("en_low", 16'h0500, 0, 0, 0);

    cmd(0, 0, 0, 1, 0, 16'h0000);
    chk_all("clr_nz", 16'h0000, 0, 0, 1);
    cmd(0, 0, 0, 1, 0, 16'h0000);
    chk_all("clr_zero", 16'h0000, 0, 0, 0);

    // Ten back-to-back increments
    for (int i = 0; i < 10; i++) cmd(1, 1, 0, 0, 0, 16'h0000);
    chk_all("ten_inc", 16'h0010, 0, 0, 1);

    // Priority
    cmd(0, 0, 0, 0, 1, 16'h0123);
    cmd(1, 1, 0, 1, 1, 16'h4567);
    chk_all("prio_clr", 16'h0000, 0, 0, 1);
    cmd(1, 1, 0, 0, 1, 16'hF3A2);
    chk_all("prio_load_sat", 16'h9392, 0, 0, 1);
    cmd(0, 0, 0, 0, 1, 16'h9392);
    chk_all("load_same", 16'h9392, 0, 0, 0);
    cmd(0, 0, 0, 0, 1, 16'h0000);
    chk_all("load_zero", 16'h0000, 0, 0, 1);

    // Mid-cycle reset kills an in-flight changed pulse
    cmd(0, 0, 0, 0, 1, 16'h0041);
    cmd(1, 1, 0, 0, 0, 16'h0000);
    chk_all("pre_rst", 16'h0042, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("mid_rst", 16'h0000, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_release", 16'h0000, 0, 0, 0);

    // Cascade: low decade carry feeds high decade inc
    for (int i = 0; i < 25; i++) begin
      lo.en = 1'b1; lo.inc = 1'b1;
      @(posedge clk); #1;
    end
    lo.inc = 1'b0; lo.en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("cascade_lo", lo.bcd, 32'h5);
    chk("cascade_hi", hi.bcd, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
